// File: rtl/fetch_ctrl.sv
// fetch_ctrl: sequencing controller for the fetch stage.
// Each cycle it picks the value loaded into the PC flip-flop (sequential,
// hold or redirect). It also drives fetch-valid and flush into the F/D
// register, and tracks start-up, branch bubbles, halt and PC faults.
// Optional performance counters are built when FETCH_CTRL_PERF_EN is defined.
// Without that macro, stall_cnt_o and flush_cnt_o are tied to zero.

module fetch_ctrl #(
  parameter int REGI_SIZE   = 16,
  parameter int MEMO_LINES  = 64,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [REGI_SIZE-1:0] pc_i,
  input  logic [REGI_SIZE-1:0] pc_plus_i,
  input  logic                 stall_i,
  input  logic                 branch_taken_i,
  input  logic [REGI_SIZE-1:0] branch_target_i,
  input  logic                 halt_instr_i,
  output logic [REGI_SIZE-1:0] next_pc_o,
  output logic                 fetch_valid_o,
  output logic                 flush_o,
  output logic                 halted_o,
  output logic                 fault_o,
  output logic [15:0]          stall_cnt_o,
  output logic [15:0]          flush_cnt_o
);

  // One extra bit so that a MEMO_LINES equal to 2^REGI_SIZE still compares correctly.
  localparam logic [REGI_SIZE:0]   MEMO_LIMIT   = (REGI_SIZE+1)'(MEMO_LINES);
  localparam logic [REGI_SIZE-1:0] LAST_PC      = REGI_SIZE'(MEMO_LINES - 1);
  localparam logic [2:0]           FLUSH_RELOAD = 3'(FLUSH_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_HALT
  } state_t;

  state_t     state;
  logic [2:0] flush_left;

  logic target_ok;
  logic pc_at_end;

  // Range checks shared by the output decode and the state machine.
  always_comb begin
    target_ok = ({1'b0, branch_target_i} < MEMO_LIMIT);
    pc_at_end = (pc_i == LAST_PC);
  end

  // Combinational fetch decisions, so the PC flip-flop updates on the same edge.
  // Reset forces the IDLE view of the outputs even before the state has cleared.
  always_comb begin
    next_pc_o     = pc_i;
    fetch_valid_o = 1'b0;
    flush_o       = 1'b0;
    if (rst_i) begin
      flush_o = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          flush_o = 1'b1;
        end
        S_RUN: begin
          if (branch_taken_i) begin
            if (target_ok) begin
              next_pc_o = branch_target_i;
              flush_o   = 1'b1;
            end
          end else if (halt_instr_i || stall_i) begin
            next_pc_o = pc_i;
          end else if (pc_at_end) begin
            fetch_valid_o = 1'b1;
          end else begin
            next_pc_o     = pc_plus_i;
            fetch_valid_o = 1'b1;
          end
        end
        S_FLUSH: begin
          if (branch_taken_i) begin
            if (target_ok) begin
              next_pc_o = branch_target_i;
              flush_o   = 1'b1;
            end
          end else begin
            next_pc_o = pc_plus_i;
            flush_o   = 1'b1;
          end
        end
        S_HALT: begin
          next_pc_o = pc_i;
        end
        default: begin
          next_pc_o = pc_i;
        end
      endcase
    end
  end

  // Control state machine with the registered halt and sticky fault flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      flush_left <= 3'd0;
      halted_o   <= 1'b0;
      fault_o    <= 1'b0;
    end else if ((state == S_RUN || state == S_FLUSH) && branch_taken_i) begin
      if (target_ok) begin
        flush_left <= FLUSH_RELOAD;
        if (FLUSH_DEPTH > 1) begin
          state <= S_FLUSH;
        end else begin
          state <= S_RUN;
        end
      end else begin
        fault_o  <= 1'b1;
        halted_o <= 1'b1;
        state    <= S_HALT;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (halt_instr_i) begin
            halted_o <= 1'b1;
            state    <= S_HALT;
          end else if (!stall_i && pc_at_end) begin
            fault_o  <= 1'b1;
            halted_o <= 1'b1;
            state    <= S_HALT;
          end
        end
        S_FLUSH: begin
          flush_left <= flush_left - 3'd1;
          if (flush_left <= 3'd1) begin
            state <= S_RUN;
          end
        end
        S_HALT: begin
          if (start_i) begin
            fault_o  <= 1'b0;
            halted_o <= 1'b0;
            state    <= S_RUN;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;
  logic        stall_win;

  // A stall only counts when no branch or halt outranks it in RUN.
  always_comb begin
    stall_win = (state == S_RUN) && !branch_taken_i && !halt_instr_i && stall_i;
  end

  // Saturating stall and bubble counters, cleared by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      if (stall_win && stall_cnt_q != 16'hFFFF) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if (state != S_IDLE && flush_o && flush_cnt_q != 16'hFFFF) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = 16'd0;
  assign flush_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed and random stimulus for fetch_ctrl.
// The bench plays the PC flip-flop. A behavioural model of the fetch rules
// predicts every output, and the model tracks bubbles as a plain count.
// The counter expectations follow the FETCH_CTRL_PERF_EN build.

module tb_fetch_ctrl;

  localparam int REGI_SIZE   = 16;
  localparam int MEMO_LINES  = 64;
  localparam int FLUSH_DEPTH = 2;
`ifdef FETCH_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [15:0] pc_i;
  logic [15:0] pc_plus_i;
  logic        stall_i;
  logic        branch_taken_i;
  logic [15:0] branch_target_i;
  logic        halt_instr_i;
  logic [15:0] next_pc_o;
  logic        fetch_valid_o;
  logic        flush_o;
  logic        halted_o;
  logic        fault_o;
  logic [15:0] stall_cnt_o;
  logic [15:0] flush_cnt_o;

  int total = 0;
  int bad   = 0;

  bit m_idle    = 1'b1;
  bit m_halted  = 1'b0;
  bit m_fault   = 1'b0;
  int m_bubbles = 0;
  int m_stalls  = 0;
  int m_flushes = 0;

  logic [15:0] pc = 16'd0;
  logic        last_valid;
  logic        last_flush;

  fetch_ctrl #(
    .REGI_SIZE  (REGI_SIZE),
    .MEMO_LINES (MEMO_LINES),
    .FLUSH_DEPTH(FLUSH_DEPTH)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .pc_i           (pc_i),
    .pc_plus_i      (pc_plus_i),
    .stall_i        (stall_i),
    .branch_taken_i (branch_taken_i),
    .branch_target_i(branch_target_i),
    .halt_instr_i   (halt_instr_i),
    .next_pc_o      (next_pc_o),
    .fetch_valid_o  (fetch_valid_o),
    .flush_o        (flush_o),
    .halted_o       (halted_o),
    .fault_o        (fault_o),
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o)
  );

  always #5 clk = ~clk;

  // Counts one comparison and reports it when the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle, checks all outputs against the model, then clocks the PC.
  task automatic applyStimulus(input bit r, input bit s, input bit st,
                               input bit b, input logic [15:0] t, input bit h);
    logic [15:0] e_next;
    logic [15:0] obs_next;
    bit e_valid, e_flush;
    bit n_idle, n_halted, n_fault;
    int n_bub, n_st, n_fl;

    @(negedge clk);
    rst_i           = r;
    start_i         = s;
    stall_i         = st;
    branch_taken_i  = b;
    branch_target_i = t;
    halt_instr_i    = h;
    pc_i            = pc;
    pc_plus_i       = pc + 16'd1;
    #1;

    e_next   = pc;
    e_valid  = 1'b0;
    e_flush  = 1'b0;
    n_idle   = m_idle;
    n_halted = m_halted;
    n_fault  = m_fault;
    n_bub    = m_bubbles;
    n_st     = m_stalls;
    n_fl     = m_flushes;

    if (r) begin
      e_flush  = 1'b1;
      n_idle   = 1'b1;
      n_halted = 1'b0;
      n_fault  = 1'b0;
      n_bub    = 0;
      n_st     = 0;
      n_fl     = 0;
    end else if (m_idle) begin
      e_flush = 1'b1;
      if (s) n_idle = 1'b0;
    end else if (m_halted) begin
      if (s) begin
        n_halted = 1'b0;
        n_fault  = 1'b0;
      end
    end else begin
      if (b) begin
        if (int'(t) < MEMO_LINES) begin
          e_next  = t;
          e_flush = 1'b1;
          n_bub   = FLUSH_DEPTH - 1;
        end else begin
          n_fault  = 1'b1;
          n_halted = 1'b1;
          n_bub    = 0;
        end
      end else if (m_bubbles > 0) begin
        e_next  = pc + 16'd1;
        e_flush = 1'b1;
        n_bub   = m_bubbles - 1;
      end else if (h) begin
        n_halted = 1'b1;
      end else if (st) begin
        if (m_stalls < 65535) n_st = m_stalls + 1;
      end else if (int'(pc) == MEMO_LINES - 1) begin
        e_valid  = 1'b1;
        n_fault  = 1'b1;
        n_halted = 1'b1;
      end else begin
        e_next  = pc + 16'd1;
        e_valid = 1'b1;
      end
      if (e_flush && m_flushes < 65535) n_fl = m_flushes + 1;
    end

    checkOutput("next_pc", 32'(next_pc_o), 32'(e_next));
    checkOutput("fetch_valid", 32'(fetch_valid_o), 32'(e_valid));
    checkOutput("flush", 32'(flush_o), 32'(e_flush));
    checkOutput("halted", 32'(halted_o), 32'(m_halted));
    checkOutput("fault", 32'(fault_o), 32'(m_fault));
    checkOutput("stall_cnt", 32'(stall_cnt_o), PERF ? 32'(m_stalls) : 32'd0);
    checkOutput("flush_cnt", 32'(flush_cnt_o), PERF ? 32'(m_flushes) : 32'd0);

    last_valid = fetch_valid_o;
    last_flush = flush_o;
    obs_next   = next_pc_o;
    @(posedge clk);
    #1;
    pc        = obs_next;
    m_idle    = n_idle;
    m_halted  = n_halted;
    m_fault   = n_fault;
    m_bubbles = n_bub;
    m_stalls  = n_st;
    m_flushes = n_fl;
  endtask

  initial begin
    rst_i           = 1'b1;
    start_i         = 1'b0;
    stall_i         = 1'b0;
    branch_taken_i  = 1'b0;
    branch_target_i = 16'd0;
    halt_instr_i    = 1'b0;
    pc_i            = 16'd0;
    pc_plus_i       = 16'd1;

    // Reset, start at 0, run sequentially.
    pc = 16'd0;
    applyStimulus(1, 0, 0, 0, 16'd0, 0);
    applyStimulus(1, 0, 0, 0, 16'd0, 0);
    checkOutput("rst_halted", 32'(halted_o), 32'd0);
    checkOutput("rst_fault", 32'(fault_o), 32'd0);
    applyStimulus(0, 1, 0, 0, 16'd0, 0);
    checkOutput("idle_valid", 32'(last_valid), 32'd0);
    repeat (4) applyStimulus(0, 0, 0, 0, 16'd0, 0);
    checkOutput("seq_pc4", 32'(pc), 32'd4);
    checkOutput("seq_valid", 32'(last_valid), 32'd1);
    applyStimulus(0, 0, 0, 0, 16'd0, 0);
    checkOutput("seq_pc5", 32'(pc), 32'd5);

    // Branch at 5 to 20, two bubble cycles.
    applyStimulus(0, 0, 0, 1, 16'd20, 0);
    checkOutput("redirect_pc", 32'(pc), 32'd20);
    checkOutput("redirect_flush", 32'(last_flush), 32'd1);
    applyStimulus(0, 0, 0, 0, 16'd0, 0);
    checkOutput("bubble_flush", 32'(last_flush), 32'd1);
    checkOutput("bubble_pc", 32'(pc), 32'd21);
    if (PERF) checkOutput("flush_cnt_2", 32'(flush_cnt_o), 32'd2);
    applyStimulus(0, 0, 0, 0, 16'd0, 0);
    checkOutput("valid_at_21", 32'(last_valid), 32'd1);

    // Three stall cycles at pc 7.
    applyStimulus(1, 0, 0, 0, 16'd0, 0);
    pc = 16'd7;
    applyStimulus(0, 1, 0, 0, 16'd0, 0);
    repeat (3) applyStimulus(0, 0, 1, 0, 16'd0, 0);
    checkOutput("stall_pc", 32'(pc), 32'd7);
    checkOutput("stall_valid", 32'(last_valid), 32'd0);
    if (PERF) checkOutput("stall_cnt_3", 32'(stall_cnt_o), 32'd3);
    applyStimulus(0, 0, 0, 0, 16'd0, 0);
    checkOutput("after_stall_pc", 32'(pc), 32'd8);

    // Branch and stall together at pc 4: the branch wins.
    applyStimulus(1, 0, 0, 0, 16'd0, 0);
    pc = 16'd4;
    applyStimulus(0, 1, 0, 0, 16'd0, 0);
    applyStimulus(0, 0, 1, 1, 16'd9, 0);
    checkOutput("br_over_stall", 32'(pc), 32'd9);
    applyStimulus(0, 0, 0, 0, 16'd0, 0);

    // Out-of-range target faults and halts; start recovers.
    applyStimulus(0, 0, 0, 1, 16'd64, 0);
    checkOutput("bad_tgt_fault", 32'(fault_o), 32'd1);
    checkOutput("bad_tgt_halted", 32'(halted_o), 32'd1);
    checkOutput("bad_tgt_pc", 32'(pc), 32'd10);
    applyStimulus(0, 0, 0, 0, 16'd0, 0);
    checkOutput("halt_pc_hold", 32'(pc), 32'd10);
    applyStimulus(0, 1, 0, 0, 16'd0, 0);
    checkOutput("resume_fault", 32'(fault_o), 32'd0);
    checkOutput("resume_halted", 32'(halted_o), 32'd0);

    // Reset arriving during a bubble.
    applyStimulus(0, 0, 0, 1, 16'd30, 0);
    applyStimulus(1, 0, 0, 0, 16'd0, 0);
    checkOutput("flush_rst_fault", 32'(fault_o), 32'd0);
    checkOutput("flush_rst_flushcnt", 32'(flush_cnt_o), 32'd0);
    checkOutput("flush_rst_stallcnt", 32'(stall_cnt_o), 32'd0);
    applyStimulus(0, 0, 0, 0, 16'd0, 0);
    checkOutput("flush_rst_valid", 32'(last_valid), 32'd0);

    // Random traffic against the model.
    pc = 16'd0;
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 79) == 0),
                    ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 7) == 0),
                    16'($urandom_range(0, 69)),
                    ($urandom_range(0, 31) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencing controller for the fetch stage. Each cycle it chooses the value presented to the PC flip-flop: sequential, hold, or redirect. It also drives the fetch-valid and bubble/flush signals into the F/D pipeline register. A small state machine handles start-up, branch-redirect bubbles and halt, and faults on out-of-range PCs.

## Interface
- REGI_SIZE, 16, PC and instruction width
- MEMO_LINES, 64, instruction memory depth; legal PCs are 0..MEMO_LINES-1
- FLUSH_DEPTH, 2, bubble cycles inserted after a taken branch (1..7)
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- start_i  in  1  leave IDLE/HALT and begin fetching at the current PC
- pc_i  in  REGI_SIZE  current PC (PC flip-flop output)
- pc_plus_i  in  REGI_SIZE  pc_i + 1 from the PC adder
- stall_i  in  1  decode hazard; hold the PC this cycle
- branch_taken_i  in  1  redirect request from execute
- branch_target_i  in  REGI_SIZE  redirect address
- halt_instr_i  in  1  decode sees the halt opcode
- next_pc_o  out  REGI_SIZE  value loaded into the PC flip-flop next edge
- fetch_valid_o  out  1  instruction fetched this cycle is real
- flush_o  out  1  clear the F/D register (and D/E on redirect) this cycle
- halted_o  out  1  controller is in HALT
- fault_o  out  1  sticky; an illegal PC was produced
- stall_cnt_o  out  16  stall cycles counted (see Configuration)
- flush_cnt_o  out  16  bubble cycles counted (see Configuration)

## Operation
- States: IDLE, RUN, FLUSH, HALT. Reset enters IDLE.
- IDLE
  - next_pc_o = pc_i; fetch_valid_o = 0; flush_o = 1.
  - start_i moves to RUN.
- RUN, priority order branch > halt > stall > sequential:
  - **branch_taken_i**
    - If branch_target_i < MEMO_LINES: next_pc_o = branch_target_i, flush_o = 1, fetch_valid_o = 0, go to FLUSH with counter = FLUSH_DEPTH-1. If FLUSH_DEPTH = 1, stay in RUN.
    - Otherwise: fault_o set, next_pc_o = pc_i, go to HALT.
  - **halt_instr_i**: next_pc_o = pc_i, fetch_valid_o = 0, go to HALT.
  - **stall_i**: next_pc_o = pc_i, fetch_valid_o = 0, flush_o = 0. The F/D register holds externally.
  - **Sequential**: next_pc_o = pc_plus_i (modulo 2^REGI_SIZE), fetch_valid_o = 1. If pc_i == MEMO_LINES-1, the fetch of pc_i is still valid, fault_o is set, next_pc_o = pc_i, and the state goes to HALT.
- FLUSH
  - next_pc_o = pc_plus_i; fetch_valid_o = 0; flush_o = 1; counter decrements; at 0 go to RUN.
  - branch_taken_i is still honoured with RUN-state semantics and reloads the counter.
  - stall_i is ignored.
- HALT
  - next_pc_o = pc_i; fetch_valid_o = 0; halted_o = 1.
  - start_i returns to RUN at pc_i and clears fault_o.
- Reset mid-operation: all state, the counter, fault_o and the perf counters clear on the next edge, whatever the other inputs are.

## Timing
- State and counter are registered. next_pc_o, fetch_valid_o and flush_o are combinational from the state and this cycle's inputs, so the PC updates on the same edge.
- Redirect latency: branch_taken_i in cycle N means pc_i = branch_target_i in N+1 and fetch_valid_o = 1 in N+FLUSH_DEPTH.
- Outputs during and after reset: state IDLE, next_pc_o = pc_i, fetch_valid_o = 0, flush_o = 1, halted_o = 0, fault_o = 0, counters = 0.
- halted_o and fault_o are registered and assert the cycle after the triggering input.
- If start_i arrives in the same cycle as a RUN-state event, start_i is ignored.

## Configuration
- FETCH_CTRL_PERF_EN defined:
  - stall_cnt_o increments each RUN cycle where stall_i wins.
  - flush_cnt_o increments each cycle flush_o = 1 outside IDLE.
  - Both saturate at 16'hFFFF and clear on reset.
- Not defined: both outputs are tied to 0 and no counter registers exist.

## Test plan
- Reset then start_i with pc from 0 and no events: pc_i sequence 0,1,2,3 and fetch_valid_o = 1 from the first RUN cycle.
- Branch at pc 5 to target 20, FLUSH_DEPTH = 2: next_pc_o = 20, flush_o high 2 cycles, fetch_valid_o returns at 21, and flush_cnt_o = 2 with the macro defined.
- stall_i held 3 cycles at pc 7: pc_i stays 7, fetch_valid_o = 0, stall_cnt_o = 3, then pc_i = 8.
- branch_taken_i and stall_i together at pc 4, target 9: the branch wins and pc_i = 9 next cycle.
- Branch target 64 with MEMO_LINES = 64: fault_o = 1 and halted_o = 1 next cycle, and pc holds; start_i then clears fault_o and resumes RUN.
- rst_i asserted in FLUSH: the next cycle is IDLE with fetch_valid_o = 0, fault_o = 0 and counters = 0.
